// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus per-channel stable-interval debouncer for slide switches.
// Optional registered change pulse sw_edge is enabled by defining SWITCH_DEBOUNCE_PULSE_EN.
module switch_debounce #(
    parameter int              WIDTH   = 2,
    parameter int              CNT_MAX = 500000,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out
`ifdef SWITCH_DEBOUNCE_PULSE_EN
    ,
    output logic [WIDTH-1:0] sw_edge
`endif
);

    localparam int               CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] out_nxt;

    // A mismatch must persist for CNT_MAX consecutive evaluations before sw_out follows;
    // any return to the current level restarts the count.
    always_comb begin
        cnt_nxt = cnt;
        out_nxt = sw_out;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_q2[i] == sw_out[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                out_nxt[i] = sync_q2[i];
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= RST_VAL;
            sync_q2 <= RST_VAL;
            sw_out  <= RST_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
            sw_out  <= out_nxt;
            cnt     <= cnt_nxt;
        end
    end

`ifdef SWITCH_DEBOUNCE_PULSE_EN
    // Pulses on exactly the edge at which sw_out takes its new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_edge <= '0;
        end else begin
            sw_edge <= out_nxt ^ sw_out;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with WIDTH=2, CNT_MAX=4, RST_VAL=00.
// The sw_edge scenario is included when SWITCH_DEBOUNCE_PULSE_EN is defined.
module tb_switch_debounce;

    localparam int WIDTH   = 2;
    localparam int CNT_MAX = 4;
    // Edges from the first edge that samples a new raw level to the sw_out change.
    localparam int LAT     = 1 + CNT_MAX;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_out;
`ifdef SWITCH_DEBOUNCE_PULSE_EN
    logic [WIDTH-1:0] sw_edge;
`endif

    int checks;
    int errors;

    switch_debounce #(
        .WIDTH   (WIDTH),
        .CNT_MAX (CNT_MAX),
        .RST_VAL (2'b00)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_raw  (sw_raw),
        .sw_out  (sw_out)
`ifdef SWITCH_DEBOUNCE_PULSE_EN
        ,
        .sw_edge (sw_edge)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] raw);
        sw_raw = raw;
        reset  = 1'b1;
        step();
        step();
        reset  = 1'b0;
    endtask

    // Raw level 11 held through reset; sw_out must stay 00, then rise at edge 1+LAT.
    task automatic test_reset();
        sw_raw = 2'b11;
        reset  = 1'b1;
        #1;
        checks++;
        if (sw_out !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: sw_out=%b expected 00", sw_out);
        end
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (sw_out !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: sw_out=%b expected 00", n, sw_out);
            end
        end
        reset = 1'b0;
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            checks++;
            if (sw_out !== ((e >= LAT + 1) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL reset_release edge%0d: sw_out=%b expected %b", e, sw_out,
                         (e >= LAT + 1) ? 2'b11 : 2'b00);
            end
        end
    endtask

    // 3-cycle pulse on bit0 must be rejected; a later full-length level must take full latency.
    task automatic test_glitch();
        do_reset(2'b00);
        sw_raw = 2'b01;
        for (int n = 0; n < 3; n++) begin
            step();
        end
        sw_raw = 2'b00;
        for (int n = 0; n < 20; n++) begin
            step();
            checks++;
            if (sw_out !== 2'b00) begin
                errors++;
                $display("FAIL glitch cyc%0d: sw_out=%b expected 00", n, sw_out);
            end
        end
        sw_raw = 2'b01;
        for (int e = 1; e <= LAT + 1; e++) begin
            step();
            checks++;
            if (sw_out !== ((e >= LAT + 1) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL glitch_recount edge%0d: sw_out=%b expected %b", e, sw_out,
                         (e >= LAT + 1) ? 2'b01 : 2'b00);
            end
        end
    endtask

    // bit1 bounces 1,0,1,0 with 2-cycle holds, then settles at 1.
    task automatic test_bounce();
        logic [WIDTH-1:0] pattern [4];
        int               trans;
        logic [WIDTH-1:0] prev;
        pattern = '{2'b10, 2'b00, 2'b10, 2'b00};
        do_reset(2'b00);
        trans = 0;
        prev  = sw_out;
        for (int p = 0; p < 4; p++) begin
            sw_raw = pattern[p];
            for (int n = 0; n < 2; n++) begin
                step();
                checks++;
                if (sw_out !== 2'b00) begin
                    errors++;
                    $display("FAIL bounce_phase%0d: sw_out=%b expected 00", p, sw_out);
                end
                if (sw_out[1] !== prev[1]) trans++;
                prev = sw_out;
            end
        end
        sw_raw = 2'b10;
        for (int e = 1; e <= LAT + 6; e++) begin
            step();
            checks++;
            if (sw_out !== ((e >= LAT + 1) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL bounce_settle edge%0d: sw_out=%b expected %b", e, sw_out,
                         (e >= LAT + 1) ? 2'b10 : 2'b00);
            end
            if (sw_out[1] !== prev[1]) trans++;
            prev = sw_out;
        end
        checks++;
        if (trans != 1) begin
            errors++;
            $display("FAIL bounce_transitions: got %0d expected 1", trans);
        end
    endtask

    // Both bits rise together; bit0 falls back after 2 cycles and must never reach sw_out.
    task automatic test_independence();
        do_reset(2'b00);
        sw_raw = 2'b11;
        for (int e = 1; e <= LAT + 4; e++) begin
            step();
            if (e == 2) sw_raw = 2'b10;
            checks++;
            if (sw_out !== ((e >= LAT + 1) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL independence edge%0d: sw_out=%b expected %b", e, sw_out,
                         (e >= LAT + 1) ? 2'b10 : 2'b00);
            end
        end
    endtask

    // Partial count must be discarded by a reset; full latency applies after release.
    task automatic test_reset_mid_count();
        do_reset(2'b00);
        sw_raw = 2'b01;
        for (int n = 0; n < 3; n++) begin
            step();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (sw_out !== 2'b00) begin
            errors++;
            $display("FAIL midreset_assert: sw_out=%b expected 00", sw_out);
        end
        step();
        step();
        reset = 1'b0;
        for (int e = 1; e <= LAT + 3; e++) begin
            step();
            checks++;
            if (sw_out !== ((e >= LAT + 1) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL midreset_release edge%0d: sw_out=%b expected %b", e, sw_out,
                         (e >= LAT + 1) ? 2'b01 : 2'b00);
            end
        end
    endtask

`ifdef SWITCH_DEBOUNCE_PULSE_EN
    // sw_edge must pulse 11 for one cycle alongside each sw_out change, 00 otherwise.
    task automatic test_edge_pulse();
        sw_raw = 2'b11;
        reset  = 1'b1;
        step();
        step();
        checks++;
        if (sw_edge !== 2'b00) begin
            errors++;
            $display("FAIL edge_in_reset: sw_edge=%b expected 00", sw_edge);
        end
        reset = 1'b0;
        for (int e = 1; e <= LAT + 3; e++) begin
            step();
            checks++;
            if (sw_out !== ((e >= LAT + 1) ? 2'b11 : 2'b00) ||
                sw_edge !== ((e == LAT + 1) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL edge_rise edge%0d: sw_out=%b sw_edge=%b expected %b %b", e,
                         sw_out, sw_edge, (e >= LAT + 1) ? 2'b11 : 2'b00,
                         (e == LAT + 1) ? 2'b11 : 2'b00);
            end
        end
        sw_raw = 2'b00;
        for (int e = 1; e <= LAT + 3; e++) begin
            step();
            checks++;
            if (sw_out !== ((e >= LAT + 1) ? 2'b00 : 2'b11) ||
                sw_edge !== ((e == LAT + 1) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL edge_fall edge%0d: sw_out=%b sw_edge=%b expected %b %b", e,
                         sw_out, sw_edge, (e >= LAT + 1) ? 2'b00 : 2'b11,
                         (e == LAT + 1) ? 2'b11 : 2'b00);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        sw_raw = 2'b00;
        test_reset();
        test_glitch();
        test_bounce();
        test_independence();
        test_reset_mid_count();
`ifdef SWITCH_DEBOUNCE_PULSE_EN
        test_edge_pulse();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
